// File: rtl/ctrl_pkg.sv
// Shared controller types: state enum, opcode/op codes, nsel/vsel encodings.
// DATAPATH_CTRL_TRAP_EN: illegal instructions halt with err until reset.
package ctrl_pkg;

  typedef enum logic [2:0] {
    S_WAIT,
    S_DECODE,
    S_GET_A,
    S_GET_B,
    S_EXEC,
    S_WR_RD,
    S_WR_IMM,
    S_HALT
  } state_t;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  localparam logic [1:0] OP_MOV_IMM = 2'b10;
  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_MVN     = 2'b11;

  localparam logic [2:0] NSEL_NONE = 3'b000;
  localparam logic [2:0] NSEL_RN   = 3'b001;
  localparam logic [2:0] NSEL_RD   = 3'b010;
  localparam logic [2:0] NSEL_RM   = 3'b100;

  localparam logic [1:0] VSEL_C   = 2'b00;
  localparam logic [1:0] VSEL_IMM = 2'b10;

`ifdef DATAPATH_CTRL_TRAP_EN
  localparam logic TRAP_EN = 1'b1;
`else
  localparam logic TRAP_EN = 1'b0;
`endif

  typedef struct packed {
    logic mov_imm;
    logic mov_reg;
    logic alu;
    logic cmp;
    logic mvn;
    logic legal;
  } dec_t;

  typedef struct packed {
    logic [2:0] nsel;
    logic [1:0] vsel;
    logic       loada;
    logic       loadb;
    logic       loadc;
    logic       loads;
    logic       asel;
    logic       bsel;
    logic       write;
    logic [1:0] aluop;
    logic       w;
    logic       err;
  } ctrl_out_t;

  function automatic ctrl_out_t out_decode(
    input state_t     st,
    input logic       mov_reg,
    input logic       cmp,
    input logic [1:0] op
  );
    ctrl_out_t o;
    o = '0;
    o.nsel = NSEL_NONE;
    o.vsel = VSEL_C;
    unique case (st)
      S_WAIT:   o.w = 1'b1;
      S_DECODE: o.w = 1'b0;
      S_GET_A: begin
        o.nsel  = NSEL_RN;
        o.loada = 1'b1;
      end
      S_GET_B: begin
        o.nsel  = NSEL_RM;
        o.loadb = 1'b1;
      end
      S_EXEC: begin
        o.aluop = op;
        o.asel  = mov_reg;
        o.loads = cmp;
        o.loadc = ~cmp;
      end
      S_WR_RD: begin
        o.nsel  = NSEL_RD;
        o.vsel  = VSEL_C;
        o.write = 1'b1;
      end
      S_WR_IMM: begin
        o.nsel  = NSEL_RN;
        o.vsel  = VSEL_IMM;
        o.write = 1'b1;
      end
      S_HALT:   o.err = TRAP_EN;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Instruction classifier: opcode/op to class flags plus legal bit.
// Purely combinational; feeds the controller FSM.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  output dec_t       dec
);

  always_comb begin
    dec         = '0;
    dec.alu     = (opcode == OPC_ALU);
    dec.mov_imm = (opcode == OPC_MOV) && (op == OP_MOV_IMM);
    dec.mov_reg = (opcode == OPC_MOV) && (op == OP_MOV_REG);
    dec.cmp     = dec.alu && (op == OP_CMP);
    dec.mvn     = dec.alu && (op == OP_MVN);
    dec.legal   = dec.alu | dec.mov_imm | dec.mov_reg;
  end

endmodule

// File: rtl/datapath_ctrl.sv
// Moore controller for the MOV/ALU datapath; outputs registered from next state.
// DATAPATH_CTRL_TRAP_EN (via ctrl_pkg) routes illegal instructions to HALT.
module datapath_ctrl
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       s,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  output logic [2:0] nsel,
  output logic [1:0] vsel,
  output logic       loada,
  output logic       loadb,
  output logic       loadc,
  output logic       loads,
  output logic       asel,
  output logic       bsel,
  output logic       write,
  output logic [1:0] aluop,
  output logic       w,
  output logic       err
);

  state_t    state_q, state_d;
  ctrl_out_t out_q, out_d;
  dec_t      dec;

  ctrl_decode u_dec (
    .opcode (opcode),
    .op     (op),
    .dec    (dec)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_WAIT:   if (s) state_d = S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          !dec.legal:          state_d = TRAP_EN ? S_HALT : S_WAIT;
          dec.mov_imm:         state_d = S_WR_IMM;
          dec.mov_reg,dec.mvn: state_d = S_GET_B;
          default:             state_d = S_GET_A;
        endcase
      end
      S_GET_A:  state_d = S_GET_B;
      S_GET_B:  state_d = S_EXEC;
      S_EXEC:   state_d = dec.cmp ? S_WAIT : S_WR_RD;
      S_WR_RD:  state_d = S_WAIT;
      S_WR_IMM: state_d = S_WAIT;
      S_HALT:   state_d = S_HALT;
    endcase
    // Decoding the next state lets outputs come straight from flops.
    out_d = out_decode(state_d, dec.mov_reg, dec.cmp, op);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_WAIT;
      out_q   <= out_decode(S_WAIT, 1'b0, 1'b0, 2'b00);
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
    end
  end

  assign nsel  = out_q.nsel;
  assign vsel  = out_q.vsel;
  assign loada = out_q.loada;
  assign loadb = out_q.loadb;
  assign loadc = out_q.loadc;
  assign loads = out_q.loads;
  assign asel  = out_q.asel;
  assign bsel  = out_q.bsel;
  assign write = out_q.write;
  assign aluop = out_q.aluop;
  assign w     = out_q.w;
  assign err   = out_q.err;

endmodule

// File: doc/datapath_ctrl.md
DATAPATH_CTRL -- requirements
Module: datapath_ctrl

Interface
REQ-001 clk  input  1  rising-edge clock; sole clock domain.
REQ-002 reset_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-003 s  input  1  start: launch one instruction when controller is idle.
REQ-004 opcode  input  3  instruction class: 110 = MOV, 101 = ALU; all other values illegal.
REQ-005 op  input  2  sub-op: MOV 10 = imm, 00 = reg; ALU 00 ADD, 01 CMP, 10 AND, 11 MVN.
REQ-006 nsel  output  3  one-hot register-file select: 001 Rn, 010 Rd, 100 Rm, 000 none.
REQ-007 vsel  output  2  writeback source: 00 = ALU result C, 10 = sximm8; other codes unused.
REQ-008 loada, loadb, loadc, loads  output  1 each  load enables: A, B, result C, status Z/N/V.
REQ-009 asel  output  1  1 = ALU A operand forced to zero.
REQ-010 bsel  output  1  1 = ALU B operand is sximm5.
REQ-011 write  output  1  register-file write enable.
REQ-012 aluop  output  2  ALU opcode forwarded to the ALU; equals op in EXEC, 00 otherwise.
REQ-013 w  output  1  1 = idle, ready for s.
REQ-014 err  output  1  illegal-instruction indicator.

Function
REQ-015 Moore FSM, states WAIT, DECODE, GET_A, GET_B, EXEC, WR_RD, WR_IMM, HALT; all outputs decoded from state (plus opcode/op where noted) only.
REQ-016 Outputs not listed as asserted in a state SHALL be 0; nsel 000, vsel 00, aluop 00.
REQ-017 WAIT: w=1; s=1 -> DECODE; s=0 -> stay.
REQ-018 DECODE: no strobes; MOV imm -> WR_IMM; MOV reg -> GET_B; MVN -> GET_B; ADD/CMP/AND -> GET_A; illegal -> see REQ-030.
REQ-019 GET_A: nsel=001, loada=1 -> GET_B.
REQ-020 GET_B: nsel=100, loadb=1 -> EXEC.
REQ-021 EXEC: aluop=op; asel=1 for MOV reg; loads=1 only for CMP; loadc=1 for all except CMP; CMP -> WAIT, else -> WR_RD.
REQ-022 WR_RD: nsel=010, vsel=00, write=1 -> WAIT.
REQ-023 WR_IMM: nsel=001, vsel=10, write=1 -> WAIT.
REQ-024 Latency s-high-in-WAIT to w-high: MOV imm 3 cycles, MOV reg/MVN 5, ADD/AND 6, CMP 5.
REQ-025 s ignored in every state except WAIT; s held high across WAIT launches back-to-back instructions with w=1 for exactly one cycle between them.
REQ-026 opcode/op SHALL be held stable by the environment while w=0; controller does not latch them.
REQ-027 write and loadc never asserted in the same cycle; write asserted at most once per instruction.

Reset
REQ-028 reset_n=0 at a rising edge forces WAIT next cycle from any state, including mid-instruction and HALT; aborted instruction produces no further strobes.
REQ-029 In reset and the first cycle after: w=1, err=0, all strobes 0, nsel 000, vsel 00, aluop 00.

Configuration
REQ-030 Macro DATAPATH_CTRL_TRAP_EN: defined -> illegal opcode/op in DECODE goes to HALT, err=1 and w=0 held until reset; undefined -> illegal goes to WAIT, HALT unreachable, err tied 0.

Structure
REQ-031 Package ctrl_pkg holds the state enum, opcode/op constants, nsel and vsel encodings; shared with the datapath.
REQ-032 One sub-module ctrl_decode (combinational: opcode, op -> instruction-class flags and legal bit) instantiated once; FSM and output decode remain in datapath_ctrl.

Verification
REQ-033 Reset then s=1 with opcode=110 op=10 -> DECODE, WR_IMM (nsel=001, vsel=10, write=1), w=1 on cycle 3.
REQ-034 ADD (101/00) -> loada (nsel=001), loadb (nsel=100), EXEC aluop=00 loadc=1, WR_RD write=1 nsel=010; w=1 at cycle 6.
REQ-035 CMP (101/01) -> EXEC loads=1, loadc=0, no write in any cycle; w=1 at cycle 5.
REQ-036 MOV reg (110/00) and MVN (101/11) -> no loada cycle; EXEC asel=1 for MOV reg only, asel=0 for MVN.
REQ-037 reset_n=0 during EXEC of ADD -> WAIT next cycle, no write strobe for that instruction.
REQ-038 opcode=111: with DATAPATH_CTRL_TRAP_EN, err=1 and w=0 until reset_n=0; without it, w=1 two cycles after s, err=0.
